// File: rtl/lcu_fifo_ctrl_pkg.sv
// Shared widths and defaults for the circular-FIFO list control unit.
package lcu_pkg;

  typedef int unsigned width_t;

  localparam width_t DEF_DATA_W = 4;
  localparam width_t DEF_DEPTH  = 8;

  // Pointer width that never collapses to zero bits.
  function automatic width_t ptr_w(input width_t depth);
    return (depth <= 2) ? width_t'(1) : width_t'($clog2(depth));
  endfunction

  // Occupancy needs one more bit than the pointer to represent DEPTH.
  function automatic width_t cnt_w(input width_t depth);
    return ptr_w(depth) + width_t'(1);
  endfunction

endpackage

// File: rtl/lcu_fifo_ctrl_if.sv
// Enqueue/dequeue, status and register-file port bundle of lcu_fifo_ctrl.
// LCU_FIFO_ERR_FLAGS_EN adds the sticky ovf/udf flags and err_clr.
interface lcu_fifo_ctrl_if
  import lcu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) ();
  localparam int unsigned AW = ptr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic              enq;
  logic [DATA_W-1:0] in;
  logic              deq;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] rd;
  logic [AW-1:0]     ra;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic              we;
`ifdef LCU_FIFO_ERR_FLAGS_EN
  logic              err_clr;
  logic              ovf;
  logic              udf;

  modport slave (
    input  enq, in, deq, rd, err_clr,
    output out, out_valid, full, empty, almost_full, almost_empty,
           count, valid, ra, wa, wd, we, ovf, udf
  );
  modport master (
    output enq, in, deq, rd, err_clr,
    input  out, out_valid, full, empty, almost_full, almost_empty,
           count, valid, ra, wa, wd, we, ovf, udf
  );
`else
  modport slave (
    input  enq, in, deq, rd,
    output out, out_valid, full, empty, almost_full, almost_empty,
           count, valid, ra, wa, wd, we
  );
  modport master (
    output enq, in, deq, rd,
    input  out, out_valid, full, empty, almost_full, almost_empty,
           count, valid, ra, wa, wd, we
  );
`endif
endinterface

// File: rtl/lcu_fifo_ctrl_ptr.sv
// Wrapping pointer register; wrap is the natural AW-bit overflow.
module lcu_ptr #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);
  logic [AW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
endmodule

// File: rtl/lcu_fifo_ctrl.sv
// Circular FIFO list control unit driving an external 1R/1W register file.
// Optional sticky overflow/underflow flags under LCU_FIFO_ERR_FLAGS_EN.
module lcu_fifo_ctrl
  import lcu_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned AE_MARGIN = 1
) (
  input logic           clk,
  input logic           rst,
  lcu_fifo_ctrl_if.slave bus
);
  localparam int unsigned AW    = ptr_w(DEPTH);
  localparam int unsigned CW    = cnt_w(DEPTH);
  // Thresholds clamped so oversized margins saturate instead of wrapping.
  localparam int unsigned AF_TH = (AF_MARGIN >= DEPTH) ? 0 : DEPTH - AF_MARGIN;
  localparam int unsigned AE_TH = (AE_MARGIN >= DEPTH) ? DEPTH : AE_MARGIN;

  logic [AW-1:0]     rp, wp;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              full_c, empty_c, enq_ok_c, deq_ok_c;

  assign full_c   = &valid_q;
  assign empty_c  = ~|valid_q;
  // A full FIFO still accepts an enqueue paired with a dequeue.
  assign enq_ok_c = bus.enq & (~full_c | bus.deq);
  assign deq_ok_c = bus.deq & ~empty_c;

  lcu_ptr #(.AW(AW)) u_rp (.clk(clk), .rst(rst), .inc(deq_ok_c), .ptr(rp));
  lcu_ptr #(.AW(AW)) u_wp (.clk(clk), .rst(rst), .inc(enq_ok_c), .ptr(wp));

  // Clear before set so a full-FIFO enq+deq on the same slot stays valid.
  always_comb begin
    valid_d     = valid_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    if (deq_ok_c) begin
      valid_d[rp] = 1'b0;
      out_d       = bus.rd;
      out_valid_d = 1'b1;
    end
    if (enq_ok_c) valid_d[wp] = 1'b1;
    if (enq_ok_c && !deq_ok_c)      count_d = count_q + CW'(1);
    else if (deq_ok_c && !enq_ok_c) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out          = out_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.count        = count_q;
  assign bus.valid        = valid_q;
  assign bus.almost_full  = (count_q >= CW'(AF_TH));
  assign bus.almost_empty = (count_q <= CW'(AE_TH));
  assign bus.ra           = rp;
  assign bus.wa           = wp;
  assign bus.wd           = bus.in;
  assign bus.we           = enq_ok_c & ~rst;

`ifdef LCU_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, udf_q, udf_d;

  // Sticky error flags; a new error wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (bus.err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.enq & full_c & ~bus.deq) ovf_d = 1'b1;
    if (bus.deq & empty_c)           udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.ovf = ovf_q;
  assign bus.udf = udf_q;
`endif
endmodule

// File: tb/tb_lcu_fifo_ctrl.sv
// Directed bench for lcu_fifo_ctrl with a queue-based reference model and a bench-side register file.
module tb_lcu_fifo_ctrl;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AFM    = 1;
  localparam int unsigned AEM    = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  lcu_fifo_ctrl_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  lcu_fifo_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, synchronous write.
  logic [DATA_W-1:0] rf [DEPTH];
  always @(posedge clk) if (bus.we) rf[bus.wa] <= bus.wd;
  assign bus.rd = rf[bus.ra];

  // Reference model: data queue plus slot positions of head and tail.
  logic [DATA_W-1:0] q[$];
  int                m_rp = 0, m_wp = 0;
  logic [DATA_W-1:0] m_out = '0;
  bit                m_ov = 1'b0;
  bit                e_ok, d_ok;
`ifdef LCU_FIFO_ERR_FLAGS_EN
  bit m_ovf = 1'b0, m_udf = 1'b0;
`endif

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rp = 0; m_wp = 0; m_out = '0; m_ov = 1'b0;
`ifdef LCU_FIFO_ERR_FLAGS_EN
      m_ovf = 1'b0; m_udf = 1'b0;
`endif
    end else begin
      e_ok = bus.enq && (q.size() < DEPTH || bus.deq);
      d_ok = bus.deq && q.size() > 0;
`ifdef LCU_FIFO_ERR_FLAGS_EN
      if (bus.err_clr) begin m_ovf = 1'b0; m_udf = 1'b0; end
      if (bus.enq && q.size() == DEPTH && !bus.deq) m_ovf = 1'b1;
      if (bus.deq && q.size() == 0) m_udf = 1'b1;
`endif
      m_ov = d_ok;
      if (d_ok) begin
        m_out = q.pop_front();
        m_rp  = (m_rp + 1) % DEPTH;
      end
      if (e_ok) begin
        q.push_back(bus.in);
        m_wp = (m_wp + 1) % DEPTH;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, mid-cycle.
  int               n;
  logic [DEPTH-1:0] ev;
  always @(negedge clk) begin
    if (chk_en) begin
      n  = q.size();
      ev = '0;
      for (int k = 0; k < n; k++) ev[(m_rp + k) % DEPTH] = 1'b1;
      chk("we",        int'(bus.we), int'(bus.enq && (n < DEPTH || bus.deq) && !rst));
      chk("wa",        int'(bus.wa), m_wp);
      chk("ra",        int'(bus.ra), m_rp);
      chk("wd",        int'(bus.wd), int'(bus.in));
      chk("count",     int'(bus.count), n);
      chk("popcount",  int'(bus.count), $countones(bus.valid));
      chk("valid",     int'(bus.valid), int'(ev));
      chk("full",      int'(bus.full), int'(n == DEPTH));
      chk("empty",     int'(bus.empty), int'(n == 0));
      chk("alm_full",  int'(bus.almost_full), int'(n >= DEPTH - AFM));
      chk("alm_empty", int'(bus.almost_empty), int'(n <= AEM));
      chk("out",       int'(bus.out), int'(m_out));
      chk("out_valid", int'(bus.out_valid), int'(m_ov));
`ifdef LCU_FIFO_ERR_FLAGS_EN
      chk("ovf",       int'(bus.ovf), int'(m_ovf));
      chk("udf",       int'(bus.udf), int'(m_udf));
`endif
    end
  end

  task automatic drive(input bit e, input bit d, input logic [DATA_W-1:0] din);
    bus.enq = e; bus.deq = d; bus.in = din;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit e, input bit d, input logic [DATA_W-1:0] din);
    drive(e, d, din);
    tick();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rf[i] = '0;
    rst = 1'b1; bus.enq = 1'b0; bus.deq = 1'b0; bus.in = '0;
`ifdef LCU_FIFO_ERR_FLAGS_EN
    bus.err_clr = 1'b0;
`endif
    tick();
    chk_en = 1'b1;
    // Enqueue held during reset must not write.
    drive(1'b1, 1'b0, 4'h3);
    chk("we_in_rst", int'(bus.we), 0);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full",  int'(bus.full), 0);
    chk("rst_count", int'(bus.count), 0);
    chk("rst_out",   int'(bus.out), 0);
    chk("rst_ov",    int'(bus.out_valid), 0);
    chk("rst_we",    int'(bus.we), 0);
    chk("rst_ae",    int'(bus.almost_empty), 1);
    chk("rst_af",    int'(bus.almost_full), 0);

    // Fill.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 4'(i + 1));
      chk("fill_wa", int'(bus.wa), i);
      tick();
    end
    chk("fill_full",  int'(bus.full), 1);
    chk("fill_valid", int'(bus.valid), 'hFF);
    chk("fill_count", int'(bus.count), 8);
    chk("fill_af",    int'(bus.almost_full), 1);
    drive(1'b1, 1'b0, 4'h9);
    chk("full_rej_we", int'(bus.we), 0);
    tick();
    chk("full_rej_count", int'(bus.count), 8);
    chk("full_rej_valid", int'(bus.valid), 'hFF);

    // Drain.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'h0);
      chk("drain_out", int'(bus.out), i + 1);
      chk("drain_ov",  int'(bus.out_valid), 1);
    end
    chk("drain_empty", int'(bus.empty), 1);
    step(1'b0, 1'b1, 4'h0);
    chk("empty_rej_ov",  int'(bus.out_valid), 0);
    chk("empty_rej_out", int'(bus.out), 8);

    // Wrap: tail crosses slot 7 -> 0 during the six-word fill.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 1));
    chk("wrap_cnt5", int'(bus.count), 5);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'h0);
      chk("wrap_out5", int'(bus.out), i + 1);
    end
    chk("wrap_cnt0", int'(bus.count), 0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 4'(i + 10));
      if (i == 2) chk("wrap_wa7", int'(bus.wa), 7);
      if (i == 3) chk("wrap_wa0", int'(bus.wa), 0);
      tick();
    end
    chk("wrap_cnt6", int'(bus.count), 6);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 4'h0);
      chk("wrap_out6", int'(bus.out), i + 10);
    end

    // Simultaneous on full: head and tail both at slot 3.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i + 8));
    drive(1'b1, 1'b1, 4'hA);
    chk("sim_wa", int'(bus.wa), 3);
    chk("sim_ra", int'(bus.ra), 3);
    chk("sim_we", int'(bus.we), 1);
    tick();
    chk("sim_out",   int'(bus.out), 8);
    chk("sim_ov",    int'(bus.out_valid), 1);
    chk("sim_full",  int'(bus.full), 1);
    chk("sim_count", int'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'h0);
      chk("sim_drain", int'(bus.out), (i < 7) ? i + 9 : 'hA);
    end
    chk("sim_empty", int'(bus.empty), 1);

    // Simultaneous on empty: enqueue only, no bypass.
    step(1'b1, 1'b1, 4'h5);
    chk("emp_sim_count", int'(bus.count), 1);
    chk("emp_sim_ov",    int'(bus.out_valid), 0);
    chk("cnt1_ae",       int'(bus.almost_empty), 1);
    chk("cnt1_af",       int'(bus.almost_full), 0);
    step(1'b1, 1'b0, 4'h6);
    chk("cnt2_ae", int'(bus.almost_empty), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(i + 7));
    chk("cnt5_af", int'(bus.almost_full), 0);
    chk("cnt5_ae", int'(bus.almost_empty), 0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 4'(i + 1));
    chk("cnt7_af",    int'(bus.almost_full), 1);
    chk("cnt7_count", int'(bus.count), 7);
    step(1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    chk("cnt5_count", int'(bus.count), 5);
    chk("cnt5_out",   int'(bus.out), 6);

    // Mid-stream reset.
    drive(1'b1, 1'b1, 4'hC);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 4'h0);
    chk("mrst_count", int'(bus.count), 0);
    chk("mrst_empty", int'(bus.empty), 1);
    chk("mrst_full",  int'(bus.full), 0);
    chk("mrst_valid", int'(bus.valid), 0);
    chk("mrst_out",   int'(bus.out), 0);
    chk("mrst_ov",    int'(bus.out_valid), 0);
    chk("mrst_wa",    int'(bus.wa), 0);
    chk("mrst_ra",    int'(bus.ra), 0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
